// File: rtl/round_arbiter_if.sv
// Handshake bundle between two sample requesters, the shared rounding stage and its consumer.
interface round_arbiter_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [IN_W-1:0]  req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [IN_W-1:0]  req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_id;
    logic             out_sat;
    logic             out_ready;
    logic [CNT_W-1:0] sat_count;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id, out_sat, sat_count
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id, out_sat, sat_count
    );
endinterface

// File: rtl/round_arbiter.sv
// Two requesters share one round-half-up / saturate stage feeding a single result register;
// ties are resolved round robin and saturated results are counted.
module round_arbiter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst,
    round_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic signed [OUT_W:0] MAX_POS = (OUT_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    function automatic logic signed [OUT_W:0] round_half_up(input logic signed [IN_W-1:0] x);
        logic signed [OUT_W:0] hi;
        logic signed [OUT_W:0] half;
        hi   = {x[IN_W-1], x[IN_W-1 -: OUT_W]};
        half = {{OUT_W{1'b0}}, x[IN_W-OUT_W-1]};
        return hi + half;
    endfunction

    function automatic logic overflows(input logic signed [OUT_W:0] s);
        return s > MAX_POS;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [OUT_W:0] s);
        return overflows(s) ? MAX_POS[OUT_W-1:0] : s[OUT_W-1:0];
    endfunction

    state_t                  state, state_nxt;
    logic                    slot_free;
    logic                    grant0, grant1, grant_any;
    logic                    last_grant;
    logic signed [IN_W-1:0]  sample_p0;
    logic signed [OUT_W:0]   sum_p0;
    logic signed [OUT_W-1:0] res_p0;
    logic                    sat_p0;
    logic signed [OUT_W-1:0] data_p1;
    logic                    id_p1;
    logic                    sat_p1;
    logic                    vld_p1;
    logic [CNT_W-1:0]        cnt;

    // Stage p0: arbitration and rounding of the granted sample
    always_comb begin
        state_nxt = state;
        slot_free = (state == EMPTY) || bus.out_ready;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!rst && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        grant_any = grant0 || grant1;
        sample_p0 = grant1 ? $signed(bus.req1_data) : $signed(bus.req0_data);
        sum_p0    = round_half_up(sample_p0);
        res_p0    = saturate(sum_p0);
        sat_p0    = overflows(sum_p0);
        case (state)
            EMPTY:   if (grant_any) state_nxt = FULL;
            FULL:    if (bus.out_ready && !grant_any) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage p1: one-entry result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            data_p1    <= '0;
            id_p1      <= 1'b0;
            sat_p1     <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                data_p1    <= res_p0;
                id_p1      <= grant1;
                sat_p1     <= sat_p0;
                last_grant <= grant1;
                if (sat_p0 && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end
        end
    end

    assign vld_p1         = (state == FULL);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.out_id     = id_p1;
    assign bus.out_sat    = sat_p1;
    assign bus.sat_count  = cnt;
endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter: directed vector table, saturation-counter run,
// and randomized traffic against a behavioural model.
module tb_round_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    round_arbiter_if #(.IN_W(16), .OUT_W(12), .CNT_W(8)) bus();

    round_arbiter #(.IN_W(16), .OUT_W(12), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rs;
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        ordy;
        logic        r0;
        logic        r1;
        logic        ov;
        logic [11:0] od;
        logic        oid;
        logic        osat;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[15];

    // behavioural model state
    logic        m_valid;
    logic [11:0] m_data;
    logic        m_id;
    logic        m_sat;
    int          m_cnt;
    logic        m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic v0, input logic [15:0] d0,
                                input logic v1, input logic [15:0] d1, input logic ordy,
                                input logic r0, input logic r1, input logic ov,
                                input logic [11:0] od, input logic oid, input logic osat,
                                input logic [7:0] cnt);
        vec_t v;
        v.rs = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.oid = oid; v.osat = osat; v.cnt = cnt;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_sat = 1'b0; m_cnt = 0; m_last = 1'b1;
    endtask

    // Round half up = floor((v + half LSB) / 16), clamped to the largest positive 12-bit value
    task automatic model_result(input logic [15:0] d, output logic [11:0] q, output logic s);
        int v;
        int r;
        v = int'($signed(d));
        r = (v + 8) >>> 4;
        if (r > 2047) begin
            q = 12'h7FF;
            s = 1'b1;
        end else begin
            q = r[11:0];
            s = 1'b0;
        end
    endtask

    task automatic model_grant(output logic g0, output logic g1);
        logic slot;
        slot = !m_valid || bus.out_ready;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && slot) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) g0 = 1'b1;
                else        g1 = 1'b1;
            end else if (bus.req0_valid) g0 = 1'b1;
            else if (bus.req1_valid)     g1 = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic [15:0] d0,
                         input logic v1, input logic [15:0] d1, input logic ordy);
        rst            = r;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.out_ready  = ordy;
        #1;
    endtask

    task automatic tick();
        logic        g0, g1, s;
        logic [11:0] q;
        model_grant(g0, g1);
        model_result(g1 ? bus.req1_data : bus.req0_data, q, s);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (g0 || g1) begin
            m_valid = 1'b1;
            m_data  = q;
            m_sat   = s;
            m_id    = g1;
            m_last  = g1;
            if (s && m_cnt < 255) m_cnt++;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic check_model_readys();
        logic g0, g1;
        model_grant(g0, g1);
        check("req0_ready", bus.req0_ready, g0);
        check("req1_ready", bus.req1_ready, g1);
    endtask

    task automatic check_model_outputs();
        check("out_valid", bus.out_valid, m_valid);
        check("out_data", bus.out_data, m_data);
        check("out_id", bus.out_id, m_id);
        check("out_sat", bus.out_sat, m_sat);
        check("sat_count", bus.sat_count, m_cnt[7:0]);
    endtask

    initial begin
        model_reset();

        // reset state, with both requesters valid so the readys must be suppressed
        drive(1'b1, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
        check("rst_req0_ready", bus.req0_ready, 1'b0);
        check("rst_req1_ready", bus.req1_ready, 1'b0);
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 12'h000);
        check("rst_out_id", bus.out_id, 1'b0);
        check("rst_out_sat", bus.out_sat, 1'b0);
        check("rst_sat_count", bus.sat_count, 8'd0);

        vecs[0]  = mk(1'b0, 1'b1, 16'h99C8, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 12'h99D, 1'b0, 1'b0, 8'd0);
        vecs[1]  = mk(1'b0, 1'b1, 16'h99C3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 12'h99C, 1'b0, 1'b0, 8'd0);
        vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7FF8, 1'b1, 1'b0, 1'b1, 1'b1, 12'h7FF, 1'b1, 1'b1, 8'd1);
        vecs[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFF8, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 8'd1);
        vecs[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFF3, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0, 8'd1);
        vecs[5]  = mk(1'b0, 1'b0, 16'h5555, 1'b0, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 8'd1);
        vecs[6]  = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd1);
        vecs[7]  = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b0, 1'b1, 1'b1, 12'h456, 1'b1, 1'b0, 8'd1);
        vecs[8]  = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd1);
        vecs[9]  = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd1);
        vecs[10] = mk(1'b0, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd1);
        vecs[11] = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd1);
        vecs[12] = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b0, 1'b1, 1'b1, 12'h456, 1'b1, 1'b0, 8'd1);
        vecs[13] = mk(1'b1, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'd0);
        vecs[14] = mk(1'b0, 1'b1, 16'h1230, 1'b1, 16'h4560, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rs, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            check($sformatf("vec%0d_req0_ready", i), bus.req0_ready, vecs[i].r0);
            check($sformatf("vec%0d_req1_ready", i), bus.req1_ready, vecs[i].r1);
            tick();
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
            check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].od);
            check($sformatf("vec%0d_out_id", i), bus.out_id, vecs[i].oid);
            check($sformatf("vec%0d_out_sat", i), bus.out_sat, vecs[i].osat);
            check($sformatf("vec%0d_sat_count", i), bus.sat_count, vecs[i].cnt);
        end

        // saturation counter must stick at its maximum
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        tick();
        for (int i = 0; i < 258; i++) begin
            drive(1'b0, 1'b1, 16'h7FF8, 1'b0, 16'h0000, 1'b1);
            tick();
            if (i == 253) check("sat_count_254", bus.sat_count, 8'd254);
        end
        check("sat_count_stuck", bus.sat_count, 8'd255);
        check("sat_out_data", bus.out_data, 12'h7FF);
        check("sat_out_sat", bus.out_sat, 1'b1);
        check("sat_out_valid", bus.out_valid, 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
            check_model_readys();
            tick();
            check_model_outputs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
